// File: rtl/z80_seq_pkg.sv
// rtl/z80_seq_pkg.sv - shared state, field encodings and prefix bytes for the Z80 prefix sequencer
//
// Contents:
//   state_t        sequencer states
//   IDX_*          index register selector (o_idx)
//   GRP_*          opcode group (o_grp)
//   PFX_*          prefix byte values DD, FD, ED, CB
//   sat_inc4       4-bit increment that sticks at 15
package z80_seq_pkg;

  typedef enum logic [2:0] {
    S_OP   = 3'd0,
    S_DISP = 3'd1,
    S_CBOP = 3'd2,
    S_IMM0 = 3'd3,
    S_IMM1 = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  localparam logic [1:0] IDX_HL = 2'b00;
  localparam logic [1:0] IDX_IX = 2'b01;
  localparam logic [1:0] IDX_IY = 2'b10;

  localparam logic [1:0] GRP_MAIN = 2'b00;
  localparam logic [1:0] GRP_CB   = 2'b01;
  localparam logic [1:0] GRP_ED   = 2'b10;
  localparam logic [1:0] GRP_PFX  = 2'b11;

  localparam logic [7:0] PFX_DD = 8'hDD;
  localparam logic [7:0] PFX_FD = 8'hFD;
  localparam logic [7:0] PFX_ED = 8'hED;
  localparam logic [7:0] PFX_CB = 8'hCB;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/z80_len_decode.sv
// rtl/z80_len_decode.sv - combinational operand-length decode for one Z80 opcode
//
// Ports:
//   grp        in   2  opcode group (GRP_MAIN or GRP_ED; others decode to no operands)
//   idx        in   2  active index register (IDX_HL means no DD/FD in effect)
//   opcode     in   8  opcode byte
//   need_disp  out  1  a displacement byte follows the opcode
//   imm_cnt    out  2  immediate bytes following the opcode (and displacement)
module z80_len_decode
  import z80_seq_pkg::*;
(
  input  logic [1:0] grp,
  input  logic [1:0] idx,
  input  logic [7:0] opcode,
  output logic       need_disp,
  output logic [1:0] imm_cnt
);

  logic hl_ref;

  // Opcodes whose (HL) operand becomes (IX+d)/(IY+d) under an index prefix.
  // 76 is HALT, not LD (HL),(HL), so it never takes a displacement.
  always_comb begin
    hl_ref = 1'b0;
    if (opcode inside {8'h34, 8'h35, 8'h36})
      hl_ref = 1'b1;
    if (opcode[7:6] == 2'b01 && opcode != 8'h76 &&
        (opcode[2:0] == 3'b110 || opcode[5:3] == 3'b110))
      hl_ref = 1'b1;
    if (opcode[7:6] == 2'b10 && opcode[2:0] == 3'b110)
      hl_ref = 1'b1;
  end

  always_comb begin
    need_disp = 1'b0;
    imm_cnt   = 2'd0;
    case (grp)
      GRP_MAIN: begin
        need_disp = (idx != IDX_HL) && hl_ref;
        if (opcode inside {8'hC3, 8'hCD, 8'h22, 8'h2A, 8'h32, 8'h3A} ||
            (opcode[7:6] == 2'b00 && opcode[3:0] == 4'b0001))
          imm_cnt = 2'd2;
        else if (opcode[7:6] == 2'b00 && opcode[2:0] == 3'b110)
          imm_cnt = 2'd1;
      end
      GRP_ED: begin
        // LD (nn),rr / LD rr,(nn)
        if (opcode[7:6] == 2'b01 && opcode[2:0] == 3'b011)
          imm_cnt = 2'd2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/z80_prefix_seq.sv
// rtl/z80_prefix_seq.sv - Z80 instruction-stream sequencer: absorbs prefixes, gathers operands, emits one record per instruction
//
// Parameters:
//   MAX_PREFIX  consecutive DD/FD bytes that force a prefix-only record (1..15)
//   IMM_W       immediate field width (16 or 24, upper bits zero)
// Ports:
//   i_clk, i_reset           clock (rising edge), asynchronous active-high reset
//   i_byte, i_valid, o_ready byte input; a byte is taken when i_valid && o_ready
//   o_ins_valid, i_ins_ready record handshake
//   o_opcode, o_idx, o_grp, o_disp, o_imm, o_len, o_pfx_cnt  record fields
//   o_ins_count              record handshake counter, present only with Z80_SEQ_COUNT_EN
module z80_prefix_seq
  import z80_seq_pkg::*;
#(
  parameter int MAX_PREFIX = 4,
  parameter int IMM_W      = 16
)(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [7:0]       i_byte,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_ins_valid,
  input  logic             i_ins_ready,
  output logic [7:0]       o_opcode,
  output logic [1:0]       o_idx,
  output logic [1:0]       o_grp,
  output logic [7:0]       o_disp,
  output logic [IMM_W-1:0] o_imm,
  output logic [3:0]       o_len,
`ifdef Z80_SEQ_COUNT_EN
  output logic [15:0]      o_ins_count,
`endif
  output logic [3:0]       o_pfx_cnt
);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, grp_q, imm_cnt_q;
  logic [7:0]       opcode_q, disp_q;
  logic [IMM_W-1:0] imm_q;
  logic [3:0]       len_q, pfx_cnt_q;

  logic accept, take;
  logic in_ed, is_ix_pfx, is_ed_pfx, is_cb_pfx, pfx_last;
  logic dec_disp;
  logic [1:0] dec_imm;

  assign accept = i_valid && o_ready;
  assign take   = (state_q == S_OUT) && i_ins_ready;

  // Once ED has been seen every following byte is the ED opcode, even DD/FD/CB/ED.
  assign in_ed     = (grp_q == GRP_ED);
  assign is_ix_pfx = !in_ed && (i_byte == PFX_DD || i_byte == PFX_FD);
  assign is_ed_pfx = !in_ed && (i_byte == PFX_ED);
  assign is_cb_pfx = !in_ed && (i_byte == PFX_CB);
  assign pfx_last  = (pfx_cnt_q == 4'(MAX_PREFIX - 1));

  z80_len_decode u_len_decode (
    .grp       (in_ed ? GRP_ED : GRP_MAIN),
    .idx       (idx_q),
    .opcode    (i_byte),
    .need_disp (dec_disp),
    .imm_cnt   (dec_imm)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_OP;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OP: if (accept) begin
        if (is_ix_pfx)      state_d = pfx_last ? S_OUT : S_OP;
        else if (is_ed_pfx) state_d = S_OP;
        else if (is_cb_pfx) state_d = (idx_q == IDX_HL) ? S_CBOP : S_DISP;
        else if (dec_disp)  state_d = S_DISP;
        else                state_d = (dec_imm != 2'd0) ? S_IMM0 : S_OUT;
      end
      // Indexed CB puts the displacement ahead of the opcode.
      S_DISP: if (accept) begin
        if (grp_q == GRP_CB) state_d = S_CBOP;
        else                 state_d = (imm_cnt_q != 2'd0) ? S_IMM0 : S_OUT;
      end
      S_CBOP: if (accept) state_d = S_OUT;
      S_IMM0: if (accept) state_d = (imm_cnt_q == 2'd2) ? S_IMM1 : S_OUT;
      S_IMM1: if (accept) state_d = S_OUT;
      S_OUT:  if (i_ins_ready) state_d = S_OP;
      default: state_d = S_OP;
    endcase
  end

  // Ready depends on registered state only, so i_ins_ready never reaches o_ready.
  always_comb begin
    o_ready     = (state_q != S_OUT);
    o_ins_valid = (state_q == S_OUT);
  end

  // Record fields start at zero for every instruction so unused fields read as 0.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset || take) begin
      idx_q     <= IDX_HL;
      grp_q     <= GRP_MAIN;
      imm_cnt_q <= 2'd0;
      opcode_q  <= 8'h00;
      disp_q    <= 8'h00;
      imm_q     <= '0;
      len_q     <= 4'd0;
      pfx_cnt_q <= 4'd0;
    end else if (accept) begin
      len_q <= sat_inc4(len_q);
      case (state_q)
        S_OP: begin
          if (is_ix_pfx) begin
            idx_q     <= (i_byte == PFX_DD) ? IDX_IX : IDX_IY;
            pfx_cnt_q <= pfx_cnt_q + 4'd1;
            if (pfx_last) begin
              grp_q    <= GRP_PFX;
              opcode_q <= i_byte;
            end
          end else if (is_ed_pfx) begin
            grp_q <= GRP_ED;
            idx_q <= IDX_HL;
          end else if (is_cb_pfx) begin
            grp_q <= GRP_CB;
          end else begin
            opcode_q  <= i_byte;
            imm_cnt_q <= dec_imm;
          end
        end
        S_DISP: disp_q        <= i_byte;
        S_CBOP: opcode_q      <= i_byte;
        S_IMM0: imm_q[7:0]    <= i_byte;
        S_IMM1: imm_q[15:8]   <= i_byte;
        default: ;
      endcase
    end
  end

  assign o_opcode  = opcode_q;
  assign o_idx     = idx_q;
  assign o_grp     = grp_q;
  assign o_disp    = disp_q;
  assign o_imm     = imm_q;
  assign o_len     = len_q;
  assign o_pfx_cnt = pfx_cnt_q;

`ifdef Z80_SEQ_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)   count_q <= 16'd0;
    else if (take) count_q <= count_q + 16'd1;
  end

  assign o_ins_count = count_q;
`endif

endmodule

// File: tb/tb_z80_prefix_seq.sv
// tb/tb_z80_prefix_seq.sv - self-checking bench for z80_prefix_seq: directed cases plus random instructions against a field-level model
module tb_z80_prefix_seq;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_byte;
  logic        i_valid;
  logic        o_ready;
  logic        o_ins_valid;
  logic        i_ins_ready;
  logic [7:0]  o_opcode;
  logic [1:0]  o_idx;
  logic [1:0]  o_grp;
  logic [7:0]  o_disp;
  logic [15:0] o_imm;
  logic [3:0]  o_len;
  logic [3:0]  o_pfx_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  z80_prefix_seq #(.MAX_PREFIX(4), .IMM_W(16)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_byte      (i_byte),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_ins_valid (o_ins_valid),
    .i_ins_ready (i_ins_ready),
    .o_opcode    (o_opcode),
    .o_idx       (o_idx),
    .o_grp       (o_grp),
    .o_disp      (o_disp),
    .o_imm       (o_imm),
    .o_len       (o_len),
    .o_pfx_cnt   (o_pfx_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: immediate bytes of an unprefixed main-group opcode, from the opcode tables.
  function automatic int model_imm(input logic [7:0] op);
    if (op == 8'hC3 || op == 8'hCD || op == 8'h22 || op == 8'h2A || op == 8'h32 || op == 8'h3A) return 2;
    if (op < 8'h40 && (op % 16) == 1) return 2;
    if (op < 8'h40 && (op % 8) == 6) return 1;
    return 0;
  endfunction

  // Model: does the opcode name (HL) as a memory operand (so IX/IY adds a displacement)?
  function automatic bit model_hl(input logic [7:0] op);
    if (op == 8'h34 || op == 8'h35 || op == 8'h36) return 1;
    if (op >= 8'h40 && op < 8'h80 && op != 8'h76 && ((op % 8) == 6 || (op >= 8'h70 && op < 8'h78))) return 1;
    if (op >= 8'h80 && op < 8'hC0 && (op % 8) == 6) return 1;
    return 0;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int guard;
    if (gap && $urandom_range(0, 2) == 0) begin
      i_byte = 8'($urandom);
      @(negedge i_clk);
    end
    guard = 0;
    while (o_ready !== 1'b1 && guard < 20) begin
      @(negedge i_clk);
      guard++;
    end
    if (guard >= 20) check("ready_timeout", 32'(o_ready), 32'd1);
    i_byte  = b;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic cmp_fields(input string tag, input logic [7:0] op, input logic [1:0] idx,
                            input logic [1:0] grp, input logic [7:0] disp, input logic [15:0] imm,
                            input logic [3:0] len, input logic [3:0] pfx);
    check({tag, ".opcode"}, 32'(o_opcode), 32'(op));
    check({tag, ".idx"},    32'(o_idx),    32'(idx));
    check({tag, ".grp"},    32'(o_grp),    32'(grp));
    check({tag, ".disp"},   32'(o_disp),   32'(disp));
    check({tag, ".imm"},    32'(o_imm),    32'(imm));
    check({tag, ".len"},    32'(o_len),    32'(len));
    check({tag, ".pfx"},    32'(o_pfx_cnt), 32'(pfx));
  endtask

  // Called at the negedge right after the last byte was accepted.
  task automatic expect_rec(input string tag, input logic [7:0] op, input logic [1:0] idx,
                            input logic [1:0] grp, input logic [7:0] disp, input logic [15:0] imm,
                            input logic [3:0] len, input logic [3:0] pfx, input int stall);
    int guard;
    check({tag, ".valid_latency"}, 32'(o_ins_valid), 32'd1);
    guard = 0;
    while (o_ins_valid !== 1'b1 && guard < 20) begin
      @(negedge i_clk);
      guard++;
    end
    cmp_fields(tag, op, idx, grp, disp, imm, len, pfx);
    check({tag, ".ready_out"}, 32'(o_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      @(negedge i_clk);
      check({tag, ".stall_valid"}, 32'(o_ins_valid), 32'd1);
      check({tag, ".stall_ready"}, 32'(o_ready), 32'd0);
      check({tag, ".stall_opcode"}, 32'(o_opcode), 32'(op));
      check({tag, ".stall_imm"}, 32'(o_imm), 32'(imm));
      check({tag, ".stall_len"}, 32'(o_len), 32'(len));
    end
    i_ins_ready = 1'b1;
    @(negedge i_clk);
    i_ins_ready = 1'b0;
    check({tag, ".released"}, 32'(o_ins_valid), 32'd0);
    check({tag, ".ready_back"}, 32'(o_ready), 32'd1);
  endtask

  logic [7:0]  bq[$];
  logic [7:0]  op, pb, b, e_disp;
  logic [15:0] e_imm;
  logic [1:0]  e_idx, e_grp;
  int          npfx, kind, ni;

  initial begin
    i_reset     = 1'b1;
    i_byte      = 8'h00;
    i_valid     = 1'b0;
    i_ins_ready = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    check("reset.ready", 32'(o_ready), 32'd1);
    check("reset.valid", 32'(o_ins_valid), 32'd0);
    cmp_fields("reset", 8'h00, 2'd0, 2'd0, 8'h00, 16'h0000, 4'd0, 4'd0);
    i_reset = 1'b0;
    @(negedge i_clk);

    // FD 06 CD with the consumer always ready
    i_ins_ready = 1'b1;
    send_byte(8'hFD, 0); send_byte(8'h06, 0); send_byte(8'hCD, 0);
    expect_rec("fd06", 8'h06, 2'd2, 2'd0, 8'h00, 16'h00CD, 4'd3, 4'd1, 0);

    send_byte(8'hDD, 0); send_byte(8'h36, 0); send_byte(8'h05, 0); send_byte(8'h7A, 0);
    expect_rec("dd36", 8'h36, 2'd1, 2'd0, 8'h05, 16'h007A, 4'd4, 4'd1, 0);

    send_byte(8'hFD, 0); send_byte(8'hCB, 0); send_byte(8'h10, 0); send_byte(8'h46, 0);
    expect_rec("fdcb", 8'h46, 2'd2, 2'd1, 8'h10, 16'h0000, 4'd4, 4'd1, 0);

    send_byte(8'hDD, 0); send_byte(8'hFD, 0); send_byte(8'h21, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    expect_rec("ddfd21", 8'h21, 2'd2, 2'd0, 8'h00, 16'h1234, 4'd5, 4'd2, 5);

    for (int k = 0; k < 4; k++) send_byte(8'hDD, 0);
    expect_rec("pfx_only", 8'hDD, 2'd1, 2'd3, 8'h00, 16'h0000, 4'd4, 4'd4, 0);
    send_byte(8'hDD, 0); send_byte(8'hDD, 0); send_byte(8'h00, 0);
    expect_rec("after_pfx", 8'h00, 2'd1, 2'd0, 8'h00, 16'h0000, 4'd3, 4'd2, 0);

    send_byte(8'hCB, 0); send_byte(8'h27, 0);
    expect_rec("cb_hl", 8'h27, 2'd0, 2'd1, 8'h00, 16'h0000, 4'd2, 4'd0, 1);

    send_byte(8'hED, 0); send_byte(8'h4B, 0); send_byte(8'h78, 0); send_byte(8'h56, 0);
    expect_rec("ed4b", 8'h4B, 2'd0, 2'd2, 8'h00, 16'h5678, 4'd4, 4'd0, 0);

    // Reset in the middle of ED 43 nn nn
    send_byte(8'hED, 0); send_byte(8'h43, 0); send_byte(8'h34, 0);
    i_reset = 1'b1;
    #1;
    check("midreset.valid", 32'(o_ins_valid), 32'd0);
    check("midreset.ready", 32'(o_ready), 32'd1);
    check("midreset.len", 32'(o_len), 32'd0);
    check("midreset.grp", 32'(o_grp), 32'd0);
    check("midreset.imm", 32'(o_imm), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    send_byte(8'h00, 0);
    expect_rec("post_reset", 8'h00, 2'd0, 2'd0, 8'h00, 16'h0000, 4'd1, 4'd0, 0);

    // Random instructions built field by field; expected record follows from the construction.
    for (int t = 0; t < 40; t++) begin
      bq.delete();
      npfx   = $urandom_range(0, 3);
      e_idx  = 2'd0;
      e_disp = 8'h00;
      e_imm  = 16'h0000;
      for (int k = 0; k < npfx; k++) begin
        pb = ($urandom_range(0, 1) == 1) ? 8'hDD : 8'hFD;
        bq.push_back(pb);
        e_idx = (pb == 8'hDD) ? 2'd1 : 2'd2;
      end
      kind = $urandom_range(0, 2);
      op   = 8'($urandom);
      ni   = 0;
      if (kind == 0) begin
        while (op == 8'hDD || op == 8'hFD || op == 8'hED || op == 8'hCB) op = 8'($urandom);
        e_grp = 2'd0;
        bq.push_back(op);
        if (e_idx != 2'd0 && model_hl(op)) begin
          e_disp = 8'($urandom);
          bq.push_back(e_disp);
        end
        ni = model_imm(op);
      end else if (kind == 1) begin
        e_grp = 2'd2;
        e_idx = 2'd0;
        bq.push_back(8'hED);
        bq.push_back(op);
        if (op >= 8'h40 && op < 8'h80 && (op % 8) == 3) ni = 2;
      end else begin
        e_grp = 2'd1;
        bq.push_back(8'hCB);
        if (e_idx != 2'd0) begin
          e_disp = 8'($urandom);
          bq.push_back(e_disp);
        end
        bq.push_back(op);
      end
      for (int k = 0; k < ni; k++) begin
        b = 8'($urandom);
        e_imm = e_imm | (16'(b) << (8 * k));
        bq.push_back(b);
      end
      foreach (bq[k]) send_byte(bq[k], 1);
      expect_rec($sformatf("rnd%0d", t), op, e_idx, e_grp, e_disp, e_imm,
                 4'(bq.size()), 4'(npfx), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
